cordic_rotation_iter: RTL

- Iterative rotation-mode CORDIC: converts polar (radius r_i, phase theta_i) to Cartesian (x_o = r·cos θ, y_o = r·sin θ).
- Used by the APSK mapper/symbol generator to produce ring constellation points.
- Also used by the demapper to rebuild candidate points from ring radius and phase.
- Performs one micro-rotation per clock and shares one adder set, trading latency for area.

---
 rtl/apsk_cordic_pkg.sv | 13 +
 rtl/cordic_microrot.sv | 37 +++
 rtl/cordic_rotation_iter.sv | 116 +++++++++++
 3 files changed

// File: rtl/apsk_cordic_pkg.sv
// Shared constants and types for the iterative CORDIC rotator.
package apsk_cordic_pkg;
  localparam int WL = 18;

  localparam logic [17:0] PI_HALF = 18'h00648;

  localparam logic [17:0] ATAN_TABLE [0:9] = '{
    18'h00324, 18'h001DA, 18'h000FA, 18'h0007F, 18'h0003F,
    18'h0001F, 18'h0000F, 18'h00008, 18'h00004, 18'h00002
  };

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation step.
module cordic_microrot #(
  parameter int WL = 18
) (
  input  logic signed [WL-1:0] x,
  input  logic signed [WL-1:0] y,
  input  logic signed [WL-1:0] z,
  input  logic        [3:0]    shift,
  input  logic signed [WL-1:0] atan,
  output logic signed [WL-1:0] x_nxt,
  output logic signed [WL-1:0] y_nxt,
  output logic signed [WL-1:0] z_nxt
);
  logic signed [WL-1:0] xs;
  logic signed [WL-1:0] ys;

  assign xs = x >>> shift;
  assign ys = y >>> shift;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    unique case (1'b1)
      !z[WL-1]: begin
        x_nxt = x - ys;
        y_nxt = y + xs;
        z_nxt = z - atan;
      end
      z[WL-1]: begin
        x_nxt = x + ys;
        y_nxt = y - xs;
        z_nxt = z + atan;
      end
    endcase
  end
endmodule

// File: rtl/cordic_rotation_iter.sv
// Iterative rotation-mode CORDIC, polar to Cartesian, one step per clock.
// Define CORDIC_GAIN_COMP_EN to pre-scale the radius by ~1/1.6468.
module cordic_rotation_iter
  import apsk_cordic_pkg::*;
#(
  parameter int WL   = apsk_cordic_pkg::WL,
  parameter int ITER = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [WL-1:0] r_i,
  input  logic [WL-1:0] theta_i,
  output logic          ready,
  output logic          valid,
  output logic [WL-1:0] x_o,
  output logic [WL-1:0] y_o
);
  localparam logic signed [WL-1:0] PH = WL'(PI_HALF);
  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t state;
  logic [3:0] cnt;
  logic signed [WL-1:0] x, y, z;
  logic signed [WL-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [WL-1:0] atan;
  logic signed [WL-1:0] r_s, th;
  logic signed [WL-1:0] x_ld, y_ld, z_ld;

  assign th = $signed(theta_i);

`ifdef CORDIC_GAIN_COMP_EN
  always_comb begin
    r_s = ($signed(r_i) >>> 1) + ($signed(r_i) >>> 3)
        - ($signed(r_i) >>> 6) - ($signed(r_i) >>> 9);
  end
`else
  assign r_s = $signed(r_i);
`endif

  // Fold the angle into [-pi/2, pi/2] so the iterations converge.
  always_comb begin
    x_ld = r_s;
    y_ld = '0;
    z_ld = th;
    unique case (1'b1)
      th > PH: begin
        x_ld = '0;
        y_ld = r_s;
        z_ld = th - PH;
      end
      th < -PH: begin
        x_ld = '0;
        y_ld = -r_s;
        z_ld = th + PH;
      end
      default: ;
    endcase
  end

  assign atan = (cnt < 4'd10) ? WL'(ATAN_TABLE[cnt]) : '0;

  cordic_microrot #(.WL(WL)) u_rot (
    .x     (x),
    .y     (y),
    .z     (z),
    .shift (cnt),
    .atan  (atan),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            x     <= x_ld;
            y     <= y_ld;
            z     <= z_ld;
            cnt   <= '0;
            ready <= 1'b0;
            state <= ROT;
          end
        end
        ROT: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          x_o   <= x;
          y_o   <= y;
          valid <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
